// File: rtl/vga_pkg.sv
// Shared VGA timing constants, update-FSM state type and a divider width helper.
package vga_pkg;

   localparam int HD = 640;
   localparam int HF = 16;
   localparam int HR = 96;
   localparam int HB = 48;
   localparam int VD = 480;
   localparam int VF = 10;
   localparam int VR = 2;
   localparam int VB = 33;
   localparam int HT = HD + HF + HR + HB;
   localparam int VT = VD + VF + VR + VB;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } upd_state_t;

   // A divide-by-1 still needs a one-bit counter so the port widths stay legal.
   function automatic int div_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate divider: one-clk pixel_tick every CLK_DIV enabled system clocks.
module pix_tick_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic pixel_tick
);

   localparam int            DW      = div_width(CLK_DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q;
   logic [DW-1:0] div_d;

   always_comb begin
      // NOTE: default first so every path assigns div_d and no latch is inferred.
      div_d = div_q;
      if (en) begin
         div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignment with an async active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   // Gated with rst_n so a divide-by-1 stays quiet while reset is held.
   assign pixel_tick = rst_n & en & (div_q == DIV_MAX);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan counters plus the vblank game-update request sequencer.
module vga_timing_ctrl
   import vga_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int HD      = vga_pkg::HD,
   parameter int HF      = vga_pkg::HF,
   parameter int HR      = vga_pkg::HR,
   parameter int HB      = vga_pkg::HB,
   parameter int VD      = vga_pkg::VD,
   parameter int VF      = vga_pkg::VF,
   parameter int VR      = vga_pkg::VR,
   parameter int VB      = vga_pkg::VB
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [9:0] h_count,
   output logic [9:0] v_count,
   output logic       pixel_tick,
   output logic       line_end,
   output logic       frame_end,
   output logic       vblank,
   output logic       upd_req,
   input  logic       upd_ack,
   output logic       overrun,
   input  logic       overrun_clr
);

   localparam int         H_TOTAL = HD + HF + HR + HB;
   localparam int         V_TOTAL = VD + VF + VR + VB;
   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_DISP  = 10'(VD);
   localparam logic [9:0] V_PRE   = 10'(VD - 1);

   logic [9:0] h_count_q, h_count_d;
   logic [9:0] v_count_q, v_count_d;
   upd_state_t state_q, state_d;
   logic       overrun_q, overrun_d;
   logic       req_start;
   logic       ovr_set;

   pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .pixel_tick (pixel_tick)
   );

   always_comb begin
      h_count_d = h_count_q;
      v_count_d = v_count_q;
      if (pixel_tick) begin
         if (h_count_q == H_LAST) begin
            h_count_d = '0;
            v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 10'd1;
         end else begin
            h_count_d = h_count_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_count_q <= '0;
         v_count_q <= '0;
         state_q   <= IDLE;
         overrun_q <= 1'b0;
      end else begin
         h_count_q <= h_count_d;
         v_count_q <= v_count_d;
         state_q   <= state_d;
         overrun_q <= overrun_d;
      end
   end

   assign line_end  = pixel_tick & (h_count_q == H_LAST);
   assign frame_end = line_end & (v_count_q == V_LAST);
   assign vblank    = (v_count_q >= V_DISP);
   assign req_start = line_end & (v_count_q == V_PRE);

   // An ack arriving with frame_end still counts as served.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req_start) state_d = REQ;
         REQ:     if (upd_ack) state_d = DONE;
                  else if (frame_end) state_d = IDLE;
         DONE:    if (frame_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A new miss beats a simultaneous clear so no overrun is lost.
   always_comb begin
      upd_req   = (state_q == REQ);
      ovr_set   = (state_q == REQ) & frame_end & ~upd_ack;
      overrun_d = overrun_q;
      if (ovr_set) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end
   end

   assign h_count = h_count_q;
   assign v_count = v_count_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench: two DUTs (divide-by-4 and divide-by-1) on a shrunken raster vs an arithmetic model.
module tb_vga_timing_ctrl;

   localparam int HD = 8;
   localparam int HF = 2;
   localparam int HR = 3;
   localparam int HB = 3;
   localparam int VD = 6;
   localparam int VF = 1;
   localparam int VR = 1;
   localparam int VB = 2;
   localparam int HT = HD + HF + HR + HB;
   localparam int VT = VD + VF + VR + VB;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic upd_ack = 1'b0;
   logic overrun_clr = 1'b0;

   logic [9:0] h_count [2];
   logic [9:0] v_count [2];
   logic       pixel_tick [2];
   logic       line_end [2];
   logic       frame_end [2];
   logic       vblank [2];
   logic       upd_req [2];
   logic       overrun [2];

   int checks = 0;
   int failures = 0;

   // Model: enabled-clock count since reset fully determines the raster position.
   longint ecnt [2];
   bit     pend [2];
   bit     served [2];
   bit     ovr [2];
   int     req_age = 0;
   int     mode = 0;
   int     ack_delay = 50;
   int     frame_idx = 0;
   int     freeze = 0;
   int     hold_rst = 0;

   always #5 clk = ~clk;

   vga_timing_ctrl #(.CLK_DIV(4), .HD(HD), .HF(HF), .HR(HR), .HB(HB),
                     .VD(VD), .VF(VF), .VR(VR), .VB(VB)) u_dut4 (
      .clk (clk), .rst_n (rst_n), .en (en),
      .h_count (h_count[0]), .v_count (v_count[0]), .pixel_tick (pixel_tick[0]),
      .line_end (line_end[0]), .frame_end (frame_end[0]), .vblank (vblank[0]),
      .upd_req (upd_req[0]), .upd_ack (upd_ack), .overrun (overrun[0]),
      .overrun_clr (overrun_clr)
   );

   vga_timing_ctrl #(.CLK_DIV(1), .HD(HD), .HF(HF), .HR(HR), .HB(HB),
                     .VD(VD), .VF(VF), .VR(VR), .VB(VB)) u_dut1 (
      .clk (clk), .rst_n (rst_n), .en (en),
      .h_count (h_count[1]), .v_count (v_count[1]), .pixel_tick (pixel_tick[1]),
      .line_end (line_end[1]), .frame_end (frame_end[1]), .vblank (vblank[1]),
      .upd_req (upd_req[1]), .upd_ack (upd_ack), .overrun (overrun[1]),
      .overrun_clr (overrun_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void scan(input int i, output int h, output int v, output bit tick);
      int     cd;
      longint pix;
      cd   = (i == 0) ? 4 : 1;
      pix  = ecnt[i] / cd;
      h    = int'(pix % HT);
      v    = int'((pix / HT) % VT);
      tick = rst_n && en && ((ecnt[i] % cd) == cd - 1);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         ecnt[i] = 0; pend[i] = 0; served[i] = 0; ovr[i] = 0;
      end
   endtask

   task automatic check_outputs();
      int h, v;
      bit tick, le, fe;
      for (int i = 0; i < 2; i++) begin
         scan(i, h, v, tick);
         le = tick && (h == HT - 1);
         fe = le && (v == VT - 1);
         check($sformatf("h_count%0d", i), 32'(h_count[i]), 32'(h));
         check($sformatf("v_count%0d", i), 32'(v_count[i]), 32'(v));
         check($sformatf("pixel_tick%0d", i), 32'(pixel_tick[i]), 32'(tick));
         check($sformatf("line_end%0d", i), 32'(line_end[i]), 32'(le));
         check($sformatf("frame_end%0d", i), 32'(frame_end[i]), 32'(fe));
         check($sformatf("vblank%0d", i), 32'(vblank[i]), 32'(v >= VD));
         check($sformatf("upd_req%0d", i), 32'(upd_req[i]), 32'(pend[i]));
         check($sformatf("overrun%0d", i), 32'(overrun[i]), 32'(ovr[i]));
      end
   endtask

   // Applies the rules of one clock edge using the inputs held across it.
   task automatic update_model();
      int h, v;
      bit tick, le, fe, start, set;
      if (!rst_n) return;
      for (int i = 0; i < 2; i++) begin
         scan(i, h, v, tick);
         le    = tick && (h == HT - 1);
         fe    = le && (v == VT - 1);
         start = le && (v == VD - 1);
         set   = pend[i] && fe && !upd_ack;
         if (pend[i]) begin
            if (upd_ack) begin pend[i] = 0; served[i] = 1; end
            else if (fe) pend[i] = 0;
         end else if (served[i]) begin
            if (fe) served[i] = 0;
         end else if (start) begin
            pend[i] = 1;
         end
         if (set) ovr[i] = 1;
         else if (overrun_clr) ovr[i] = 0;
         if (en) ecnt[i]++;
         if (i == 0) begin
            if (start && !pend[0]) req_age = 0;
            if (pend[0]) req_age++;
            if (fe) begin
               frame_idx++;
               mode      = (frame_idx < 5) ? frame_idx : int'($urandom_range(0, 4));
               ack_delay = int'($urandom_range(1, 300));
            end
         end
      end
   endtask

   task automatic step();
      int h, v;
      bit tick, fe0;
      @(negedge clk);
      if (hold_rst > 0) begin
         rst_n = 1'b0;
         hold_rst--;
      end else begin
         rst_n = 1'b1;
      end
      if (freeze > 0) begin
         en = 1'b0;
         freeze--;
      end else begin
         en = ($urandom_range(0, 19) != 0);
      end
      scan(0, h, v, tick);
      fe0 = tick && (h == HT - 1) && (v == VT - 1);
      case (mode)
         0:       upd_ack = ($urandom_range(0, 24) == 0);
         2:       upd_ack = fe0;
         4:       upd_ack = pend[0] && (req_age == ack_delay);
         default: upd_ack = 1'b0;
      endcase
      overrun_clr = (mode == 3) ? fe0 : ($urandom_range(0, 29) == 0);
      #1 check_outputs();
      @(posedge clk);
      update_model();
   endtask

   initial begin
      int wait_cnt;
      model_reset();
      mode     = 0;
      hold_rst = 3;
      rst_n    = 1'b0;
      en       = 1'b1;
      repeat (3000) step();

      freeze = 50;
      repeat (3000) step();

      // Reset asserted while a request is outstanding.
      wait_cnt = 0;
      while (!pend[0] && wait_cnt < 3000) begin
         step();
         wait_cnt++;
      end
      check("req_seen_before_reset", 32'(pend[0]), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_upd_req", 32'(upd_req[0]), 32'd0);
      check("async_rst_overrun", 32'(overrun[0]), 32'd0);
      check("async_rst_h_count", 32'(h_count[0]), 32'd0);
      check("async_rst_v_count", 32'(v_count[0]), 32'd0);
      check("async_rst_pixel_tick1", 32'(pixel_tick[1]), 32'd0);
      hold_rst = 2;
      repeat (6000) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequencer for the VGA output path: divides the system clock into a pixel-rate enable and runs the horizontal/vertical scan counters that feed the combinational sync decoder (h_sync, v_sync, video_on). It also schedules game-state updates: during vertical blank it raises an update request to the game logic, waits for acknowledge, and flags an overrun if the update misses the blanking window. It sits between the top-level clock/reset and both the sync decoder and the game-logic/renderer blocks.

## Interface
- CLK_DIV, 4: system clocks per pixel; legal range 1..16.
- HD, 640: horizontal display pixels.
- HF, 16: horizontal front porch.
- HR, 96: horizontal retrace.
- HB, 48: horizontal back porch.
- VD, 480: vertical display lines.
- VF, 10: vertical front porch.
- VR, 2: vertical retrace.
- VB, 33: vertical back porch.

Ports:
- clk  in  1  system clock. One clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  run enable; 0 freezes the divider and counters.
- h_count  out  10  horizontal position, 0..HT-1 (HT=HD+HF+HR+HB=800).
- v_count  out  10  vertical line, 0..VT-1 (VT=VD+VF+VR+VB=525).
- pixel_tick  out  1  one-clk strobe per pixel.
- line_end  out  1  pixel_tick & h_count==HT-1.
- frame_end  out  1  line_end & v_count==VT-1.
- vblank  out  1  v_count >= VD.
- upd_req  out  1  registered update request to the game logic.
- upd_ack  in  1  update complete; single-clk pulse or level.
- overrun  out  1  sticky: an update missed vblank.
- overrun_clr  in  1  clears overrun.

## Operation
- Divider: counter div, 0..CLK_DIV-1, width max(1,clog2(CLK_DIV)). Advances when en=1 and wraps to 0. pixel_tick = en & (div==CLK_DIV-1) is combinational. With CLK_DIV=1, pixel_tick = en.
- Scan counters update on pixel_tick only:
  - h_count increments. At HT-1 it wraps to 0 and v_count increments.
  - v_count wraps from VT-1 to 0 in the same edge.
  - No other values are reachable.
- line_end, frame_end and vblank are combinational decodes of registered state.
- Update FSM, states IDLE, REQ, DONE:
  - IDLE -> REQ on the clk edge where v_count goes VD-1 -> VD (line_end & v_count==VD-1). upd_req rises on that same edge.
  - REQ -> DONE when upd_ack=1. upd_req drops on that edge.
  - REQ -> IDLE on frame_end with upd_ack=0. On that edge, overrun is set and upd_req drops.
  - DONE -> IDLE on frame_end.
  - upd_ack outside REQ is ignored.
- Simultaneous events:
  - upd_ack and frame_end in REQ: ack wins, no overrun.
  - overrun set and overrun_clr on the same edge: set wins.
- en=0: divider, counters and pixel_tick freeze, and the FSM cannot advance on counter events. REQ still accepts upd_ack. overrun_clr still works.
- Reset (asynchronous assert; release synchronous to clk):
  - div, h_count and v_count = 0.
  - FSM = IDLE, upd_req = 0, overrun = 0.
  - pixel_tick = 0 while rst_n=0; line_end, frame_end and vblank = 0.
  - Reset mid-REQ drops upd_req immediately and does not set overrun.

## Timing
- First pixel_tick comes CLK_DIV clks after reset release with en=1.
- Line = HT*CLK_DIV clks (3200 at defaults). Frame = HT*VT*CLK_DIV clks (1,680,000).
- Decoder outputs derived from h_count/v_count have zero added latency. Counters are registered.
- upd_req window is VB+VR+VF lines = 45 lines, i.e. 144,000 clks at defaults.
- overrun asserts exactly on the frame_end edge. Earliest upd_ack honoured is the clk after upd_req rises.

## Structure
- Shared package vga_pkg holds:
  - timing constants HD, HF, HR, HB, VD, VF, VR, VB, HT, VT;
  - the FSM state enum upd_state_t {IDLE, REQ, DONE}.
- The sync decoder imports the same constants.
- One sub-module, pix_tick_gen (parameter CLK_DIV; ports clk, rst_n, en, pixel_tick), holds the divider. Counters and FSM stay in vga_timing_ctrl.

## Test plan
- Reset, en=1, CLK_DIV=4 -> pixel_tick every 4th clk, first at clk 4. h_count reaches 799 then 0, and v_count goes 0->1 on that edge.
- Run one full frame -> frame_end exactly once per 1,680,000 clks. vblank high for v_count 480..524. Counters wrap 799/524 -> 0/0.
- upd_ack 100 clks after upd_req rises -> upd_req high from the v_count 479->480 edge for 100 clks, then low. State DONE until frame_end, overrun stays 0.
- Never ack -> upd_req drops and overrun=1 on the frame_end edge. overrun_clr pulse clears it. Clear on the same edge as a new set -> overrun stays 1.
- upd_ack asserted on the frame_end edge while in REQ -> no overrun, FSM to DONE then IDLE.
- en=0 for 50 clks mid-line -> h_count, div and pixel_tick frozen and resume exactly. rst_n low mid-REQ -> all outputs 0 asynchronously, overrun 0.
